// File: rtl/lut_factorial_param.sv
// Factorial engine: small operands come from a constant table, larger ones are
// multiplied out one factor per clock. Optional saturation: LUT_FACTORIAL_OVERFLOW_EN.
module lut_factorial_param #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 64,
  parameter int LUT_DEPTH = 8
) (
  input  logic             clk_32b,
  input  logic             resetn_32b,
  input  logic             start,
  input  logic [IN_W-1:0]  source_number,
  output logic [OUT_W-1:0] factorial,
  output logic             output_ready,
  output logic             busy,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request sampled only when idle/done (busy=0); the
  // result is valid while output_ready=1 and stays until the next accepted start.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LUT  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int IDX_W = $clog2(LUT_DEPTH);

  function automatic logic [OUT_W-1:0] fact(input int m);
    logic [OUT_W-1:0] r;
    r = 1;
    for (int i = 2; i <= m; i++) r = r * OUT_W'(i);
    return r;
  endfunction

  localparam logic [OUT_W-1:0] ACC_INIT = fact(LUT_DEPTH - 1);
  localparam logic [IN_W:0]    K_INIT   = (IN_W + 1)'(LUT_DEPTH);

  state_t              state, state_next;
  logic [IN_W-1:0]     n_q;
  logic [OUT_W-1:0]    acc;
  logic [IN_W:0]       k;
  logic [OUT_W+IN_W-1:0] prod;
  logic                small_n, last_mul, ovf_hit, accept;
  logic [OUT_W-1:0]    fact_table [2**IDX_W];

  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_table
    assign fact_table[g] = (g < LUT_DEPTH) ? fact(g) : '0;
  end

  // k never exceeds n, so its low IN_W bits are the full multiplier.
  assign prod     = {{IN_W{1'b0}}, acc} * {{OUT_W{1'b0}}, k[IN_W-1:0]};
  assign last_mul = (k == {1'b0, n_q});
  assign small_n  = ({1'b0, source_number} < K_INIT);
  assign accept   = ((state == IDLE) || (state == DONE)) && start;

`ifdef LUT_FACTORIAL_OVERFLOW_EN
  assign ovf_hit = |prod[OUT_W+IN_W-1:OUT_W];
`else
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[OUT_W+IN_W-1:OUT_W];
  assign ovf_hit = 1'b0;
`endif

  always_ff @(posedge clk_32b or negedge resetn_32b) begin
    if (!resetn_32b) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = small_n ? LUT : MUL;
      LUT:        state_next = DONE;
      MUL:        if (last_mul || ovf_hit) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_32b or negedge resetn_32b) begin
    if (!resetn_32b) begin
      n_q          <= '0;
      acc          <= '0;
      k            <= '0;
      factorial    <= '0;
      output_ready <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            n_q          <= source_number;
            output_ready <= 1'b0;
            overflow     <= 1'b0;
            if (!small_n) begin
              acc <= ACC_INIT;
              k   <= K_INIT;
            end
          end else if (state == DONE) begin
            // Result was written on the edge that entered DONE; flag it one edge later.
            output_ready <= 1'b1;
          end
        end
        LUT: factorial <= fact_table[n_q[IDX_W-1:0]];
        MUL: begin
          acc <= prod[OUT_W-1:0];
          k   <= k + 1'b1;
          if (ovf_hit) begin
            factorial <= '1;
            overflow  <= 1'b1;
          end else if (last_mul) begin
            factorial <= prod[OUT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == LUT) || (state == MUL);
  assign state_dbg = state;

endmodule

// File: tb/tb_lut_factorial_param.sv
// Directed bench for lut_factorial_param with default parameters; expectations
// depend on whether LUT_FACTORIAL_OVERFLOW_EN is defined for the build.
module tb_lut_factorial_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src;
  logic [63:0] fact;
  logic        rdy, busy, ovf;
  logic [1:0]  st;

  int n_checks = 0;
  int n_fail   = 0;
  logic excl_bad = 1'b0;

  always #5 clk = ~clk;

  lut_factorial_param dut (
    .clk_32b       (clk),
    .resetn_32b    (rst_n),
    .start         (start),
    .source_number (src),
    .factorial     (fact),
    .output_ready  (rdy),
    .busy          (busy),
    .overflow      (ovf),
    .state_dbg     (st)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] n);
    start = 1'b1;
    src   = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until output_ready; -1 on timeout.
  task automatic wait_ready(output int edges);
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy && rdy) excl_bad = 1'b1;
      if (rdy) break;
    end
    if (!rdy) edges = -1;
  endtask

  task automatic run(input string tag, input logic [31:0] n, input logic [63:0] exp,
                     input int exp_edges, input logic exp_ovf);
    int e;
    start_op(n);
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    wait_ready(e);
    check_eq({tag, "_edges"}, 64'(e), 64'(exp_edges));
    check_eq({tag, "_value"}, fact, exp);
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic seen;
    rst_n = 1'b0;
    start = 1'b0;
    src   = '0;
    #12;
    check_eq("rst_fact", fact, 64'd0);
    check_eq("rst_rdy", 64'(rdy), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_state", 64'(st), 64'd0);

    // Start accepted on the first rising edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    run("n0", 32'd0, 64'd1, 2, 1'b0);
    run("n7", 32'd7, 64'd5040, 2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_value", fact, 64'd5040);
    check_eq("hold_rdy", 64'(rdy), 64'd1);

    run("n20", 32'd20, 64'h21C3677C82B40000, 14, 1'b0);
`ifdef LUT_FACTORIAL_OVERFLOW_EN
    run("n21", 32'd21, 64'hFFFFFFFFFFFFFFFF, 15, 1'b1);
`else
    run("n21", 32'd21, 64'hC5077D36B8C40000, 15, 1'b0);
`endif

    // Start re-pulsed with n=3 while busy must be ignored.
    start_op(32'd15);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    src   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("repulse_busy", 64'(busy), 64'd1);
    wait_ready(e);
    if (e >= 0) e = e + 3;
    check_eq("repulse_edges", 64'(e), 64'd9);
    check_eq("repulse_value", fact, 64'd1307674368000);

    // Start in DONE: output_ready drops on the accepting edge.
    start_op(32'd3);
    check_eq("done_start_rdy", 64'(rdy), 64'd0);
    wait_ready(e);
    check_eq("done_start_edges", 64'(e), 64'd2);
    check_eq("done_start_value", fact, 64'd6);

    // Asynchronous reset in the middle of a long multiply.
    start_op(32'd18);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_fact", fact, 64'd0);
    check_eq("mid_rst_rdy", 64'(rdy), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_ovf", 64'(ovf), 64'd0);
    check_eq("mid_rst_state", 64'(st), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rdy) seen = 1'b1;
    end
    check_eq("mid_rst_no_rdy", 64'(seen), 64'd0);
    run("n5", 32'd5, 64'd120, 2, 1'b0);

    check_eq("busy_rdy_exclusive", 64'(excl_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_factorial_param.md
LUT_FACTORIAL_PARAM -- requirements
Module: lut_factorial_param

Interface
REQ-001 Parameter IN_W, default 32: width of source_number.
REQ-002 Parameter OUT_W, default 64: width of factorial; the product is always held modulo 2^OUT_W.
REQ-003 Parameter LUT_DEPTH, default 8, legal 2..20: n < LUT_DEPTH is answered from the table; (LUT_DEPTH-1)! shall fit in OUT_W bits.
REQ-004 clk_32b  input  1  clock; all state updates on the rising edge.
REQ-005 resetn_32b  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request; sampled only in IDLE or DONE.
REQ-007 source_number  input  IN_W  operand n; captured with an accepted start.
REQ-008 factorial  output  OUT_W  result n!; valid while output_ready=1.
REQ-009 output_ready  output  1  level; high in DONE until the next accepted start.
REQ-010 busy  output  1  high in LUT or MUL state.
REQ-011 overflow  output  1  true n! exceeded OUT_W bits; valid with output_ready.

Function
REQ-012 States: IDLE, LUT, MUL, DONE; the state register is binary encoded.
REQ-013 IDLE/DONE with start=1: capture n and clear output_ready and overflow; n < LUT_DEPTH -> LUT, else -> MUL.
REQ-014 On entry to MUL: acc = (LUT_DEPTH-1)!, k = LUT_DEPTH.
REQ-015 LUT: factorial = table[n] (0!=1, 1!=1, ...); next state DONE; output_ready is high 2 edges after the start edge.
REQ-016 MUL, each edge: acc = acc*k (OUT_W x IN_W multiply, full-width product formed), then k = k+1.
REQ-017 The edge that multiplies by k=n moves MUL to DONE; output_ready is high n-LUT_DEPTH+2 edges after the start edge.
REQ-018 start while busy=1 is ignored; source_number is not re-sampled.
REQ-019 start in DONE is accepted exactly like start in IDLE; output_ready falls on the accepting edge.
REQ-020 IDLE/DONE with start=0: hold state, factorial, output_ready and overflow.
REQ-021 The k counter is IN_W+1 bits wide, so it does not wrap before reaching n = 2^IN_W-1.
REQ-022 busy and output_ready are never high together.

Reset
REQ-023 resetn_32b=0 forces IDLE asynchronously, regardless of the clock.
REQ-024 Reset values: factorial=0, output_ready=0, busy=0, overflow=0, acc=0, k=0.
REQ-025 Reset mid-MUL abandons the operation; no output_ready is produced afterwards for it.
REQ-026 The first start is accepted on the first rising edge after resetn_32b rises.

Configuration
REQ-027 Macro LUT_FACTORIAL_OVERFLOW_EN controls overflow detection; the overflow port is always present.
REQ-028 Macro defined, MUL state: if the product bits above OUT_W are nonzero, go to DONE on that edge with overflow=1 and factorial all-ones (saturated); remaining multiplies are skipped.
REQ-029 Macro not defined: overflow is tied 0, factorial holds n! mod 2^OUT_W, and MUL always runs to k=n.

Verification
REQ-030 Defaults, n=0 then n=7 -> factorial=1 and factorial=5040; each with output_ready high 2 edges after start.
REQ-031 Defaults, n=20 -> factorial=0x21C3677C82B40000 (2432902008176640000), overflow=0, output_ready high at edge 14.
REQ-032 Defaults, n=21, macro defined -> overflow=1, factorial=0xFFFFFFFFFFFFFFFF, output_ready high at edge 15.
REQ-033 Defaults, n=21, macro not defined -> overflow=0, factorial=0xC5077D36B8C40000.
REQ-034 n=15, start re-pulsed with n=3 mid-MUL -> n=3 is ignored and the result is 1307674368000; a new start in DONE with n=3 -> 6 after 2 edges.
REQ-035 n=18, resetn_32b=0 for one cycle mid-MUL -> all outputs 0 immediately, no output_ready; a following start with n=5 -> 120.
